adc_capture_gate: RTL and testbench

ADC_CAPTURE_GATE -- requirements
Module: adc_capture_gate

---
 rtl/adc_capture_gate_pkg.sv | 17 +
 rtl/adc_capture_gate_lane_clip.sv | 20 ++
 rtl/adc_capture_gate.sv | 182 ++++++++++++++++++
 tb/tb_adc_capture_gate.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_gate_pkg.sv
// Shared constants and types for the ADC capture gate.
package adc_capture_gate_pkg;

  localparam int unsigned LANE_W   = 16;
  localparam int unsigned SAMPLE_W = 14;
  localparam int unsigned MAG_W    = SAMPLE_W + 1;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/adc_capture_gate_lane_clip.sv
// Per-lane magnitude compare: flags a 14-bit signed sample with |x| >= threshold.
module adc_lane_clip
  import adc_capture_gate_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] clip_i,
  output logic                over_c
);

  logic [MAG_W-1:0] ext;
  logic [MAG_W-1:0] mag;

  // One extra bit so that |-8192| is representable without wrapping.
  always_comb begin
    ext    = {sample_i[SAMPLE_W-1], sample_i};
    mag    = ext[MAG_W-1] ? (~ext + MAG_W'(1)) : ext;
    over_c = (mag >= {1'b0, clip_i});
  end

endmodule

// File: rtl/adc_capture_gate.sv
// Triggered ADC capture gate: arm, wait for trigger edge, delay, forward a burst of words.
module adc_capture_gate
  import adc_capture_gate_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      adc_clk,
  input  logic                      adc_resetn,
  input  logic                      adc_valid,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trig,
  input  logic [CNT_WIDTH-1:0]      cfg_delay,
  input  logic [CNT_WIDTH-1:0]      cfg_len,
  input  logic                      cfg_cont,
  input  logic [SAMPLE_W-1:0]       cfg_clip,
  input  logic                      adc_wovf,
  output logic                      adc_wr,
  output logic [ADC_DATA_WIDTH-1:0] adc_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [STATE_W-1:0]        state,
  output logic                      ovf_sticky,
  output logic [CNT_WIDTH-1:0]      clip_cnt
);

  localparam int unsigned LANES = ADC_DATA_WIDTH / LANE_W;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]      delay_q, delay_d;
  logic [CNT_WIDTH-1:0]      len_q, len_d;
  logic                      cont_q, cont_d;
  logic [SAMPLE_W-1:0]       clip_q, clip_d;
  logic                      trig_d_q;
  logic                      wr_q, wr_d;
  logic [ADC_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]      clip_cnt_q, clip_cnt_d;
  logic [LANES-1:0]          lane_over;
  logic                      trig_edge;
  logic                      stat_clear;

  // Clip detection on every lane of the incoming word.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    adc_lane_clip u_clip (
      .sample_i (adc_data[g*LANE_W +: SAMPLE_W]),
      .clip_i   (clip_q),
      .over_c   (lane_over[g])
    );
  end

  // State, latched configuration, counters and registered outputs.
  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      delay_q    <= '0;
      len_q      <= '0;
      cont_q     <= 1'b0;
      clip_q     <= '0;
      trig_d_q   <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      len_q      <= len_d;
      cont_q     <= cont_d;
      clip_q     <= clip_d;
      trig_d_q   <= trig;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  // Next-state and output logic; abort overrides everything else.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    delay_d    = delay_q;
    len_d      = len_q;
    cont_d     = cont_q;
    clip_d     = clip_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    ovf_d      = ovf_q;
    clip_cnt_d = clip_cnt_q;
    stat_clear = 1'b0;
    trig_edge  = trig & ~trig_d_q;
    cnt_inc    = cnt_q + CNT_WIDTH'(1);

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d    = ST_ARMED;
            delay_d    = cfg_delay;
            len_d      = cfg_len;
            cont_d     = cfg_cont;
            clip_d     = cfg_clip;
            stat_clear = 1'b1;
          end
        end
        ST_ARMED: begin
          if (trig_edge) begin
            cnt_d   = '0;
            state_d = (delay_q != '0) ? ST_DELAY : ST_CAPTURE;
          end
        end
        ST_DELAY: begin
          cnt_d = cnt_inc;
          if (cnt_inc == delay_q) begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (len_q == '0) begin
            state_d = ST_DONE;
          end else if (adc_valid) begin
            wr_d    = 1'b1;
            wdata_d = adc_data;
            cnt_d   = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = ST_DONE;
            end
          end
          if (adc_wovf) begin
            ovf_d = 1'b1;
          end
        end
        ST_DONE: begin
          cnt_d = '0;
          if (cont_q) begin
            state_d    = ST_ARMED;
            stat_clear = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (wr_d && (|lane_over) && (clip_cnt_q != '1)) begin
        clip_cnt_d = clip_cnt_q + CNT_WIDTH'(1);
      end
      if (stat_clear) begin
        ovf_d      = 1'b0;
        clip_cnt_d = '0;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign adc_wr     = wr_q;
  assign adc_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state      = state_q;
  assign ovf_sticky = ovf_q;
  assign clip_cnt   = clip_cnt_q;

endmodule

// File: tb/tb_adc_capture_gate.sv
// Randomized self-checking bench for adc_capture_gate against a burst-level model.
module tb_adc_capture_gate;

  logic        adc_clk = 1'b0;
  logic        adc_resetn = 1'b0;
  logic        adc_valid = 1'b0;
  logic [63:0] adc_data = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [15:0] cfg_len = '0;
  logic        cfg_cont = 1'b0;
  logic [13:0] cfg_clip = '0;
  logic        adc_wovf = 1'b0;
  logic        adc_wr;
  logic [63:0] adc_wdata;
  logic        busy;
  logic        done;
  logic [2:0]  state;
  logic        ovf_sticky;
  logic [15:0] clip_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam int HIST = 20000;
  bit          valid_h [HIST];
  bit          wovf_h  [HIST];
  logic [63:0] data_h  [HIST];

  int          wr_cyc[$];
  logic [63:0] wr_dat[$];
  int          done_cyc[$];
  logic [63:0] pat [4];

  adc_capture_gate #(.ADC_DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .adc_clk    (adc_clk),
    .adc_resetn (adc_resetn),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .arm        (arm),
    .abort      (abort),
    .trig       (trig),
    .cfg_delay  (cfg_delay),
    .cfg_len    (cfg_len),
    .cfg_cont   (cfg_cont),
    .cfg_clip   (cfg_clip),
    .adc_wovf   (adc_wovf),
    .adc_wr     (adc_wr),
    .adc_wdata  (adc_wdata),
    .busy       (busy),
    .done       (done),
    .state      (state),
    .ovf_sticky (ovf_sticky),
    .clip_cnt   (clip_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  // Edge counter plus a record of the stimulus sampled at each edge.
  always @(posedge adc_clk) begin
    if (cyc + 1 < HIST) begin
      valid_h[cyc+1] <= adc_valid;
      wovf_h[cyc+1]  <= adc_wovf;
      data_h[cyc+1]  <= adc_data;
    end
    cyc <= cyc + 1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge adc_clk) begin
    if (adc_resetn) begin
      if (adc_wr) begin
        wr_cyc.push_back(cyc);
        wr_dat.push_back(adc_wdata);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cyc.delete();
    wr_dat.delete();
    done_cyc.delete();
  endtask

  function automatic bit word_clips(input logic [63:0] w, input int clip);
    bit hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [13:0] raw = w[16*k +: 14];
      int v = int'(raw);
      if (v >= 8192) v -= 16384;
      if (v < 0) v = -v;
      if (v >= clip) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic arm_with(input int d, input int len, input bit cont, input int clip);
    cfg_delay = 16'(d);
    cfg_len   = 16'(len);
    cfg_cont  = cont;
    cfg_clip  = 14'(clip);
    arm = 1'b1;
    step();
    arm = 1'b0;
    cfg_delay = 16'($urandom_range(40));
    cfg_len   = 16'($urandom_range(40));
    cfg_cont  = 1'($urandom);
    cfg_clip  = 14'($urandom);
  endtask

  // One armed capture; expectations come from the recorded stimulus.
  task automatic run_cap(input int d, input int len, input int vprob, input bit use_pat,
                         input int wovf_at, input bit rand_trig, input int clip,
                         output int first_off);
    int e0, s, n, done_exp, clip_exp;
    bit ovf_exp;
    int exp_cyc[$];
    logic [63:0] exp_dat[$];
    clear_mon();
    arm_with(d, len, 1'b0, clip);
    check_eq("arm_state", 64'(state), 64'd1);
    check_eq("arm_clip_clear", 64'(clip_cnt), 64'd0);
    check_eq("arm_ovf_clear", 64'(ovf_sticky), 64'd0);
    trig = 1'b1;
    step();
    e0 = cyc;
    for (int k = 0; k < d + 4*len + 40; k++) begin
      adc_valid = ($urandom_range(99) < vprob);
      adc_data  = use_pat ? pat[k%4] : {$urandom, $urandom};
      adc_wovf  = (wovf_at >= 0) ? (k == wovf_at) : ($urandom_range(9) == 0);
      if (rand_trig) trig = 1'($urandom);
      else if (k == 1) trig = 1'b0;
      step();
      if (done_cyc.size() != 0) break;
    end
    adc_valid = 1'b0;
    adc_wovf  = 1'b0;
    trig      = 1'b0;
    step();
    step();
    s = e0 + d + 1;
    n = 0;
    done_exp = -1;
    if (len == 0) done_exp = s;
    else
      for (int e = s; e <= cyc; e++)
        if (valid_h[e] && n < len) begin
          exp_cyc.push_back(e);
          exp_dat.push_back(data_h[e]);
          n++;
          if (n == len) done_exp = e;
        end
    ovf_exp = 1'b0;
    for (int e = s; e <= done_exp; e++) if (wovf_h[e]) ovf_exp = 1'b1;
    clip_exp = 0;
    foreach (exp_dat[i]) if (word_clips(exp_dat[i], clip)) clip_exp++;
    check_eq("wr_count", 64'(wr_cyc.size()), 64'(exp_cyc.size()));
    for (int i = 0; i < wr_cyc.size() && i < exp_cyc.size(); i++) begin
      check_eq("wr_cycle", 64'(wr_cyc[i]), 64'(exp_cyc[i]));
      check_eq("wr_data", wr_dat[i], exp_dat[i]);
    end
    check_eq("done_count", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) check_eq("done_cycle", 64'(done_cyc[0]), 64'(done_exp));
    check_eq("clip_cnt", 64'(clip_cnt), 64'(clip_exp));
    check_eq("ovf_sticky", 64'(ovf_sticky), 64'(ovf_exp));
    check_eq("end_state_idle", 64'(state), 64'd0);
    check_eq("end_busy", 64'(busy), 64'd0);
    first_off = (wr_cyc.size() > 0) ? wr_cyc[0] - e0 : -1;
  endtask

  initial begin
    int off;
    pat[0] = 64'h0000_0000_0000_1FFF;
    pat[1] = 64'h0000_0000_0000_2000;
    pat[2] = 64'h0000_0000_0000_0064;
    pat[3] = 64'h0000_0000_0000_0000;

    // Reset state
    repeat (3) step();
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_wr", 64'(adc_wr), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    adc_resetn = 1'b1;
    step();

    // Trigger without arm does nothing
    clear_mon();
    adc_valid = 1'b1;
    trig = 1'b1; step(); trig = 1'b0; step(); step();
    check_eq("noarm_writes", 64'(wr_cyc.size()), 64'd0);
    check_eq("noarm_state", 64'(state), 64'd0);
    adc_valid = 1'b0;

    // Abort wins over simultaneous arm
    abort = 1'b1; arm = 1'b1; step(); abort = 1'b0; arm = 1'b0;
    check_eq("abort_arm_state", 64'(state), 64'd0);

    // delay=3, len=8, valid held high
    run_cap(3, 8, 100, 1'b0, -1, 1'b0, 8191, off);
    check_eq("first_wr_latency", 64'(off), 64'd4);

    // len=0
    run_cap(2, 0, 100, 1'b0, -1, 1'b0, 8191, off);

    // Clip pattern and overflow flag
    run_cap(0, 4, 100, 1'b1, 1, 1'b0, 8000, off);
    check_eq("clip_pattern", 64'(clip_cnt), 64'd2);
    check_eq("ovf_set", 64'(ovf_sticky), 64'd1);
    repeat (3) step();
    check_eq("ovf_hold", 64'(ovf_sticky), 64'd1);

    // Continuous mode, 3 triggers, extra edge inside each capture
    clear_mon();
    arm_with(0, 4, 1'b1, 8191);
    check_eq("cont_armed_clear", 64'(ovf_sticky), 64'd0);
    adc_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      trig = 1'b1; step(); trig = 1'b0; step();
      trig = 1'b1; step(); trig = 1'b0;
      repeat (6) step();
    end
    check_eq("cont_writes", 64'(wr_cyc.size()), 64'd12);
    check_eq("cont_dones", 64'(done_cyc.size()), 64'd3);
    check_eq("cont_rearmed", 64'(state), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    check_eq("cont_abort_state", 64'(state), 64'd0);
    adc_valid = 1'b0;

    // Abort after 5 of 10 words
    clear_mon();
    arm_with(0, 10, 1'b0, 8191);
    adc_valid = 1'b1;
    trig = 1'b1; step(); trig = 1'b0;
    repeat (5) step();
    abort = 1'b1; arm = 1'b1; trig = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0; trig = 1'b0;
    check_eq("abort_wr_low", 64'(adc_wr), 64'd0);
    check_eq("abort_state", 64'(state), 64'd0);
    repeat (3) step();
    check_eq("abort_writes", 64'(wr_cyc.size()), 64'd5);
    check_eq("abort_no_done", 64'(done_cyc.size()), 64'd0);
    adc_valid = 1'b0;

    // Randomized captures with random trigger activity inside the burst
    for (int r = 0; r < 8; r++)
      run_cap($urandom_range(5), $urandom_range(12), 70, 1'b0, -1, 1'b1,
              $urandom_range(8191), off);

    // Reset in mid-capture
    arm_with(1, 20, 1'b0, 0);
    adc_valid = 1'b1;
    adc_data  = 64'h1234_5678_9ABC_DEF0;
    trig = 1'b1; step();
    repeat (4) step();
    #2 adc_resetn = 1'b0;
    #1;
    check_eq("mid_rst_wr", 64'(adc_wr), 64'd0);
    check_eq("mid_rst_wdata", adc_wdata, 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_state", 64'(state), 64'd0);
    check_eq("mid_rst_ovf", 64'(ovf_sticky), 64'd0);
    check_eq("mid_rst_clip", 64'(clip_cnt), 64'd0);
    repeat (2) step();
    #2 adc_resetn = 1'b1;
    clear_mon();
    for (int t = 0; t < 3; t++) begin
      step(); trig = 1'b0; step(); trig = 1'b1;
    end
    step(); step();
    check_eq("post_rst_writes", 64'(wr_cyc.size()), 64'd0);
    check_eq("post_rst_state", 64'(state), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
